mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped serial transmitter on the CPU memory bus, in the upper address window the SRAM does not decode (address[15]=1). It answers CPU reads and writes to a four-word register window, buffers written bytes in a small FIFO, and serialises them as 8N1 frames on a single TX line. It gives test programs a console output path without simulator-only system tasks.

## Interface
- BASE_ADDR, 16'hFFF0, word address of register 0; must be 4-aligned with bit 15 set.
- FIFO_DEPTH, 8, TX FIFO entries; a power of two from 2 to 16.
- RESET_BAUDDIV, 16'd16, reset value of the bit-period register, in clocks per bit.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- address  in  16  CPU address bus.
- data  inout  16  CPU data bus; driven only during a selected read, Z otherwise.
- memNotRead  in  1  active-low read strobe.
- memNotWrite  in  1  active-low write strobe.
- txd  out  1  serial output; idle high.
- irq  out  1  high when the FIFO is empty and the transmitter is idle.

## Operation
- Select: sel = (address[15:2] == BASE_ADDR[15:2]). Register index is address[1:0].
- Register 0, TXDATA, write-only: a write pushes data[7:0]. Reads return 0.
- Register 1, STATUS, read-only:
  - bit0 busy, meaning the FSM is not in IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow, sticky.
  - bits[8:4] FIFO count.
  - All other bits read 0.
- Register 2, BAUDDIV, read/write, 16-bit: bit period in clocks. A write of 0 stores 1.
- Register 3: reserved; reads return 0 and writes are ignored.
- Bus events:
  - Strobes are registered once per cycle, and edge detection is done on the registered value.
  - An access is the first cycle in which a strobe is sampled low while sel=1.
  - Exactly one action happens per strobe assertion, however long the strobe stays low.
  - If both strobes are low, the cycle is a write and data is not driven.
- Read data: data = register value, combinationally, whenever sel && !memNotRead && memNotWrite.
- Overflow:
  - A push while the FIFO is full is dropped and sets overflow.
  - A STATUS read event clears overflow after the cycle in which it is returned.
  - Full is evaluated before any same-cycle pop, so a push on full is dropped even when a pop happens in the same cycle.
- Transmit FSM: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. This pops the FIFO, loads the shift register and loads the bit counter with BAUDDIV.
  - START drives txd=0 for BAUDDIV clocks, then goes to DATA.
  - DATA shifts out 8 bits LSB first, each for BAUDDIV clocks, then goes to STOP.
  - STOP drives txd=1 for BAUDDIV clocks. It then goes to START (with a pop) if the FIFO is non-empty, else to IDLE. There are no idle gaps between back-to-back frames.
- BAUDDIV is latched per bit at the start of each bit. A write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - txd=1, irq=1, data=Z.
  - FIFO empty, overflow=0, FSM IDLE.
  - BAUDDIV=RESET_BAUDDIV.
- Reset mid-frame aborts the frame immediately: txd goes high asynchronously and FIFO contents are discarded.
- Write latency:
  - The strobe is sampled low on edge N, and the push is visible in count after edge N+1.
  - With an idle FSM, txd falls after edge N+2.
- Frame length is exactly 10*BAUDDIV clocks.
- irq is registered and falls 1 cycle after the first push into an idle, empty block.

## Structure
- Shared package/header holds:
  - register offsets (REG_TXDATA=0, REG_STATUS=1, REG_BAUDDIV=2);
  - STATUS bit positions;
  - FSM state encodings (2-bit).
- One sub-module, uart_fifo: synchronous FIFO with push, pop, full, empty and count, parameterised by width and depth.
- The top level holds bus decode, strobe edge detection, the registers and the transmit FSM.

## Test plan
- Reset with the FIFO holding 3 bytes mid-frame -> txd=1 at once, STATUS reads 16'h0004, BAUDDIV reads RESET_BAUDDIV.
- BAUDDIV=4, write 16'h1255 to TXDATA -> txd pattern 0,1,0,1,0,1,0,1,0,1, each level for 4 clocks; the upper byte is ignored; irq returns high after the stop bit.
- Hold memNotWrite low for 20 cycles on a TXDATA write -> exactly one byte pushed, so STATUS count=1 (or the frame is started).
- Write 11 bytes back-to-back with BAUDDIV=100 -> full set; overflow set after the 10th write (8 queued, 1 in flight, 1 dropped); the next STATUS read shows bit3=1 and the following read shows bit3=0; exactly 9 frames emitted with no gaps.
- Write BAUDDIV=0, then read it -> returns 1; frames use 1 clock per bit.
- Read with address[15]=0, or an unselected address -> data stays Z; a selected read of register 3 -> 16'h0000.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets within the four-word window, STATUS bit positions and the
// transmit FSM state encoding.
// ---------------------------------------------------------------------------
package mmio_uart_tx_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Single-clock show-ahead FIFO. rd_data always presents the oldest entry.
// A push while full is ignored, even if a pop happens in the same cycle;
// a pop while empty is ignored.
//
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-high reset (pointers/count only)
//   push     in   write request, wr_data is stored when not full
//   wr_data  in   DATA_W-bit write data
//   pop      in   read request, discards the head entry when not empty
//   rd_data  out  head entry
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module uart_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 serial transmitter in the upper address window.
// Four-word register window at BASE_ADDR:
//   +0 TXDATA  (W)  push data[7:0] into the TX FIFO
//   +1 STATUS  (R)  {count[8:4], overflow, empty, full, busy}
//   +2 BAUDDIV (RW) clocks per bit, a write of 0 stores 1
//   +3 reserved
//
// Ports:
//   clock        in     system clock, rising edge
//   reset        in     asynchronous active-high reset
//   address      in     CPU address bus
//   data         inout  CPU data bus, driven only during a selected read
//   memNotRead   in     active-low read strobe
//   memNotWrite  in     active-low write strobe
//   txd          out    serial output, idle high
//   irq          out    FIFO empty and transmitter idle (registered)
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR     = 16'hFFF0,
   parameter int          FIFO_DEPTH    = 8,
   parameter logic [15:0] RESET_BAUDDIV = 16'd16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   inout  wire  [15:0] data,
   input  logic        memNotRead,
   input  logic        memNotWrite,
   output logic        txd,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   function automatic logic [15:0] sat_baud(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

   logic        sel;
   logic        rd_drive;
   logic [15:0] rdata;
   logic [15:0] status_w;

   logic        wr_act_p0, wr_act_p1;
   logic        rd_act_p0, rd_act_p1;
   logic [1:0]  idx_p0;
   logic [15:0] wdata_p0;
   logic        wr_ev;
   logic        rd_ev;
   logic        push_req;

   logic [15:0] baud_q;
   logic        ovf_q;

   logic [7:0]    fifo_rd_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_q, bit_d;
   logic        pop;
   logic        txd_d;
   logic        bit_end;

   assign sel      = (address[15:2] == BASE_ADDR[15:2]);
   assign rd_drive = sel && !memNotRead && memNotWrite;

   // ---- combinational read path -------------------------------------------
   always_comb begin
      status_w                         = '0;
      status_w[ST_BUSY]                = (state_q != S_IDLE);
      status_w[ST_FULL]                = fifo_full;
      status_w[ST_EMPTY]               = fifo_empty;
      status_w[ST_OVF]                 = ovf_q;
      status_w[ST_CNT_MSB:ST_CNT_LSB]  = 5'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      case (address[1:0])
         REG_STATUS:  rdata = status_w;
         REG_BAUDDIV: rdata = baud_q;
         default:     rdata = '0;
      endcase
   end

   assign data = rd_drive ? rdata : 16'hzzzz;

   // ---- p0/p1: registered strobes, one event per strobe assertion ---------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_act_p0 <= 1'b0;
         wr_act_p1 <= 1'b0;
         rd_act_p0 <= 1'b0;
         rd_act_p1 <= 1'b0;
      end else begin
         wr_act_p0 <= sel && !memNotWrite;
         wr_act_p1 <= wr_act_p0;
         rd_act_p0 <= sel && !memNotRead && memNotWrite;
         rd_act_p1 <= rd_act_p0;
      end
   end

   always_ff @(posedge clock) begin
      idx_p0   <= address[1:0];
      wdata_p0 <= data;
   end

   assign wr_ev    = wr_act_p0 && !wr_act_p1;
   assign rd_ev    = rd_act_p0 && !rd_act_p1;
   assign push_req = wr_ev && (idx_p0 == REG_TXDATA);

   // ---- register updates ---------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         baud_q <= RESET_BAUDDIV;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_ev && (idx_p0 == REG_BAUDDIV)) begin
            baud_q <= sat_baud(wdata_p0);
         end
         // A new drop wins over a clearing read in the same cycle.
         if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
         end else if (rd_ev && (idx_p0 == REG_STATUS)) begin
            ovf_q <= 1'b0;
         end
      end
   end

   uart_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push_req),
      .wr_data (wdata_p0[7:0]),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // ---- transmit FSM -------------------------------------------------------
   // cnt_q counts clocks left in the current bit; it is reloaded from
   // baud_q at every bit start, so BAUDDIV writes apply at the next bit.
   assign bit_end = (cnt_q == 16'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 16'd1;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_rd_data;
               cnt_d   = baud_q;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = baud_q;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = baud_q;
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_rd_data;
                  cnt_d   = baud_q;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      txd_d = 1'b1;
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shreg_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd1;
         bit_q   <= 3'd0;
         txd     <= 1'b1;
         irq     <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         txd     <= txd_d;
         irq     <= fifo_empty && (state_q == S_IDLE);
      end
   end

   always_ff @(posedge clock) begin
      shreg_q <= shreg_d;
   end

endmodule
